// File: rtl/pipTypes.sv
// rtl/pipTypes.sv - shared types for the multiply/divide sequencer
package pipTypes;

    // Operations EX can present to the multiply/divide unit
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_MADD = 3'd2,
        OP_DIV  = 3'd3,
        OP_MTHI = 3'd4,
        OP_MTLO = 3'd5,
        OP_MFHI = 3'd6,
        OP_MFLO = 3'd7
    } muldiv_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } muldiv_state_t;

    localparam int unsigned MULDIV_ITERS = 32;

    // Magnitude of a 32-bit operand; unsigned operands pass through raw
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// rtl/muldiv_fixup.sv - sign correction and MADD accumulate for the final HI/LO write
module muldiv_fixup
    import pipTypes::*;
(
    input  muldiv_op_t  op,
    input  logic        sign_a,
    input  logic        sign_b,
    input  logic        div_by_zero,
    input  logic [63:0] acc,
    input  logic [31:0] rem,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    output logic [31:0] hi_new,
    output logic [31:0] lo_new
);

    logic        neg_res;
    logic [63:0] prod_signed;
    logic [63:0] madd_sum;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;

    // Signed results are formed from magnitudes, so only the final sign is applied here
    always_comb begin
        neg_res     = sign_a ^ sign_b;
        prod_signed = neg_res ? (~acc + 64'd1) : acc;
        madd_sum    = prod_signed + {hi_cur, lo_cur};
        quo_signed  = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_signed  = sign_a ? (~rem + 32'd1) : rem;

        hi_new = hi_cur;
        lo_new = lo_cur;
        case (op)
            OP_MUL: begin
                hi_new = prod_signed[63:32];
                lo_new = prod_signed[31:0];
            end
            OP_MADD: begin
                hi_new = madd_sum[63:32];
                lo_new = madd_sum[31:0];
            end
            OP_DIV: begin
                if (div_by_zero) begin
                    // Upper accumulator half holds the raw dividend for this case
                    hi_new = acc[63:32];
                    lo_new = 32'hFFFF_FFFF;
                end else begin
                    hi_new = rem_signed;
                    lo_new = quo_signed;
                end
            end
            default: begin
                hi_new = hi_cur;
                lo_new = lo_cur;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer owning HI/LO
module muldiv_seq
    import pipTypes::*;
#(
    parameter int COUNT_WIDTH = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        op_valid,
    input  muldiv_op_t  muldiv_op,
    input  logic        muldiv_op_u,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        kill,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(MULDIV_ITERS - 1);

    muldiv_state_t          state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    // MUL: {upper, multiplier}. DIV: {raw dividend, quotient}.
    logic [63:0]            acc_q, acc_d;
    logic [31:0]            rem_q, rem_d;
    // Multiplicand for MUL/MADD, divisor for DIV
    logic [31:0]            opnd_q, opnd_d;
    logic                   sign_a_q, sign_a_d;
    logic                   sign_b_q, sign_b_d;
    logic                   dbz_q, dbz_d;
    muldiv_op_t             op_q, op_d;
    logic [31:0]            hi_q, hi_d;
    logic [31:0]            lo_q, lo_d;

    logic [31:0]            mag_a;
    logic [31:0]            mag_b;
    logic [32:0]            mul_sum;
    logic [32:0]            div_shift;
    logic                   div_ge;
    logic [31:0]            fix_hi;
    logic [31:0]            fix_lo;

    muldiv_fixup u_fixup (
        .op          (op_q),
        .sign_a      (sign_a_q),
        .sign_b      (sign_b_q),
        .div_by_zero (dbz_q),
        .acc         (acc_q),
        .rem         (rem_q),
        .hi_cur      (hi_q),
        .lo_cur      (lo_q),
        .hi_new      (fix_hi),
        .lo_new      (fix_lo)
    );

    // Next-state, datapath iteration and HI/LO write selection
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        mag_a     = mag32(a, !muldiv_op_u);
        mag_b     = mag32(b, !muldiv_op_u);
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
        div_shift = {rem_q, acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opnd_q});

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    case (muldiv_op)
                        OP_MUL, OP_MADD, OP_DIV: begin
                            op_d     = muldiv_op;
                            sign_a_d = !muldiv_op_u && a[31];
                            sign_b_d = !muldiv_op_u && b[31];
                            count_d  = '0;
                            rem_d    = 32'd0;
                            if (muldiv_op == OP_DIV) begin
                                acc_d   = {a, mag_a};
                                opnd_d  = mag_b;
                                dbz_d   = (b == 32'd0);
                                state_d = (b == 32'd0) ? FIXUP : RUN;
                            end else begin
                                acc_d   = {32'd0, mag_b};
                                opnd_d  = mag_a;
                                dbz_d   = 1'b0;
                                state_d = RUN;
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    if (op_q == OP_DIV) begin
                        rem_d = div_ge ? 32'(div_shift - {1'b0, opnd_q}) : div_shift[31:0];
                        acc_d = {acc_q[63:32], acc_q[30:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_COUNT) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!kill) begin
                    hi_d = fix_hi;
                    lo_d = fix_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= 64'd0;
            rem_q    <= 32'd0;
            opnd_q   <= 32'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            op_q     <= OP_NONE;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Status outputs seen by EX
    always_comb begin
        hi    = hi_q;
        lo    = lo_q;
        busy  = (state_q != IDLE);
        done  = (state_q == FIXUP) && !kill;
        stall = op_valid && busy && (muldiv_op != OP_NONE);
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    import pipTypes::*;

    logic        clock;
    logic        reset_n;
    logic        op_valid;
    muldiv_op_t  muldiv_op;
    logic        muldiv_op_u;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    muldiv_seq #(.COUNT_WIDTH(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .op_valid    (op_valid),
        .muldiv_op   (muldiv_op),
        .muldiv_op_u (muldiv_op_u),
        .a           (a),
        .b           (b),
        .kill        (kill),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .stall       (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n edges and settle just after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Present an op for one edge (T0); returns at the T0+1 sample point
    task automatic issue(input muldiv_op_t op, input logic u, input logic [31:0] va, input logic [31:0] vb);
        op_valid    = 1'b1;
        muldiv_op   = op;
        muldiv_op_u = u;
        a           = va;
        b           = vb;
        tick(1);
        op_valid    = 1'b0;
        muldiv_op   = OP_NONE;
        muldiv_op_u = 1'b0;
        #1;
    endtask

    // Full-length op: check done at T0+33 and results at T0+34
    task automatic run_long(input string tag, input muldiv_op_t op, input logic u,
                            input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, u, va, vb);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        tick(31);
        check({tag, "_nodone_early"}, {31'd0, done}, 32'd0);
        tick(1);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        tick(1);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    int n;
    int done_cnt;

    initial begin
        reset_n     = 1'b0;
        op_valid    = 1'b0;
        muldiv_op   = OP_NONE;
        muldiv_op_u = 1'b0;
        a           = 32'd0;
        b           = 32'd0;
        kill        = 1'b0;
        tick(2);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_flags", {29'd0, busy, done, stall}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        // Signed MULT -3 x 7
        run_long("mult_neg", OP_MUL, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // DIVU 100 / 7
        run_long("divu", OP_DIV, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

        // DIV -7 / 2
        run_long("div_neg", OP_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Signed overflow case
        run_long("div_ovf", OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Divide by zero: FIXUP at T0+1, result at T0+2
        issue(OP_DIV, 1'b0, 32'd5, 32'd0);
        check("dbz_done", {30'd0, busy, done}, 32'd3);
        tick(1);
        check("dbz_hi", hi, 32'd5);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        check("dbz_idle", {31'd0, busy}, 32'd0);

        // MADDU accumulate with carry into HI
        issue(OP_MTHI, 1'b0, 32'd0, 32'd0);
        issue(OP_MTLO, 1'b0, 32'hFFFF_FFFF, 32'd0);
        check("mt_hi", hi, 32'd0);
        check("mt_lo", lo, 32'hFFFF_FFFF);
        run_long("maddu", OP_MADD, 1'b1, 32'd1, 32'd1, 32'd1, 32'd0);

        // Hazard stall: MULTU 2x3 then MFLO at T0+1
        issue(OP_MUL, 1'b1, 32'd2, 32'd3);
        op_valid  = 1'b1;
        muldiv_op = OP_NONE;
        #1;
        check("alu_nostall", {31'd0, stall}, 32'd0);
        muldiv_op = OP_MFLO;
        #1;
        n = 0;
        while (stall && n < 50) begin
            n++;
            tick(1);
        end
        check("hazard_stall_cycles", n, 32'd33);
        check("hazard_mflo", lo, 32'd6);
        check("hazard_hi", hi, 32'd0);
        op_valid  = 1'b0;
        muldiv_op = OP_NONE;
        tick(1);

        // Kill at T0+10: no write, no done
        issue(OP_MUL, 1'b1, 32'd9, 32'd9);
        tick(9);
        check("kill_busy_before", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        check("kill_busy_after", {31'd0, busy}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) done_cnt++;
            tick(1);
        end
        check("kill_no_done", done_cnt, 32'd0);
        check("kill_hi", hi, 32'd0);
        check("kill_lo", lo, 32'd6);

        // Reset mid-operation at T0+5
        issue(OP_MUL, 1'b1, 32'd4, 32'd5);
        tick(4);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_flags", {30'd0, busy, done}, 32'd0);
        #2;
        reset_n = 1'b1;
        tick(3);
        check("rst_stays_idle", {30'd0, busy, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the architectural HI/LO registers for the EX stage. It replaces single-cycle behavioural `*`, `/` and `%` with a radix-2 shift-add multiplier and a restoring divider. Both run on operand magnitudes under a small FSM. MUL/MADD/DIV issue without blocking the pipeline. Only a later HI/LO access or muldiv issue stalls EX while the unit is busy.

## Interface

- `COUNT_WIDTH`, default 6: iteration counter width; must hold 32.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  EX holds a real instruction this cycle (not bubble, not front-stalled).
- `muldiv_op`  in  `muldiv_op_t`  OP_NONE/OP_MUL/OP_MADD/OP_DIV/OP_MTHI/OP_MTLO/OP_MFHI/OP_MFLO.
- `muldiv_op_u`  in  1  unsigned variant (MULTU/MADDU/DIVU).
- `a`  in  32  forwarded rs value.
- `b`  in  32  forwarded rt value.
- `kill`  in  1  abort the in-flight operation; HI/LO are left unchanged.
- `hi`  out  32  architectural HI; reset 0.
- `lo`  out  32  architectural LO; reset 0.
- `busy`  out  1  operation in flight (state != IDLE); reset 0.
- `done`  out  1  one-cycle pulse in the FIXUP cycle; reset 0.
- `stall`  out  1  `op_valid` && `busy` && `muldiv_op` != OP_NONE; reset 0.

## Operation

- FSM states: IDLE, RUN, FIXUP.
- **Accept:** in IDLE with `op_valid`, an op of MUL, MADD or DIV is accepted. The unit captures `|a|`, `|b|`, sign_a, sign_b, op and unsigned, then goes to RUN with count=0. With unsigned=1, magnitudes are the raw operands and signs are 0.
- **MTHI/MTLO:** in IDLE with `op_valid`, write `a` into HI or LO at the edge. No state change.
- **MFHI/MFLO:** combinational reads of `hi`/`lo`. They are stalled while busy.
- **RUN, MUL:** 64-bit accumulator P = {upper, multiplier}. Each cycle, if P[0], add the multiplicand to upper (33-bit sum). Then shift P right 1.
- **RUN, DIV:** remainder R (33 bits) and quotient Q. Each cycle: shift {R,Q} left 1, trial-subtract the divisor, and keep the result and set Q[0] if it is non-negative.
- RUN ends after 32 iterations (count==31 goes to FIXUP).
- **DIV by zero:** skip RUN and go IDLE→FIXUP. Result is hi=`a`, lo=32'hFFFF_FFFF, independent of signedness.
- **FIXUP, MUL:** negate the 64-bit product (two's complement) if sign_a^sign_b.
- **FIXUP, MADD:** same negation, then add {hi,lo} modulo 2^64.
- **FIXUP, DIV:** negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
- **FIXUP, all ops:** write HI/LO at the edge, pulse `done`, return to IDLE.
- **Signed overflow:** 0x8000_0000 / 0xFFFF_FFFF gives lo=0x8000_0000, hi=0. No trap.
- **Kill:** `kill` in RUN or FIXUP returns the unit to IDLE at the next edge with no HI/LO write and no `done`. `kill` in IDLE is ignored.
- **Reset mid-operation:** immediately forces IDLE, hi=lo=0, busy=done=0.
- **Stalled requests:** while `stall` is high, EX holds the request stable. It is re-evaluated every cycle and accepted in the first IDLE cycle.

## Timing

- **MUL/MADD/DIV latency:** accept edge at T0, RUN for T0+1..T0+32, FIXUP at T0+33. New HI/LO are visible from T0+34.
- **DIV by zero latency:** FIXUP at T0+1; result visible at T0+2.
- **`busy`:** high from T0+1 through the FIXUP cycle.
- **Back-to-back issue:** a dependent MFLO issued at T0+1 stalls 33 cycles and reads the new LO at T0+34. A second MULT follows the same rule and is accepted at T0+34.
- **MT write vs FIXUP:** the MTHI/MTLO write and the FIXUP write cannot coincide, because MT* stalls while busy.

## Structure

- `muldiv_op_t`, including OP_NONE, and the state enum `muldiv_state_t` belong in `pipTypes`.
- One sub-module, `muldiv_fixup`, holds the combinational sign correction and MADD accumulate. It keeps the 64-bit adder/negator separate from the FSM.
- EX drops its own HI/LO registers and counter. It ORs `stall` into its existing stall and muxes `hi`/`lo` for MFHI/MFLO.

## Test plan

- **MULT:** -3 × 7 signed → hi=FFFF_FFFF, lo=FFFF_FFEB at T0+34; `done` at T0+33.
- **DIVU / DIV:** DIVU 100/7 → lo=14, hi=2. DIV -7/2 → lo=FFFF_FFFD, hi=FFFF_FFFF.
- **Divide by zero:** DIV 5/0 → hi=5, lo=FFFF_FFFF at T0+2. DIV 8000_0000/FFFF_FFFF → lo=8000_0000, hi=0.
- **MADDU:** MTHI 0, MTLO FFFF_FFFF, then MADDU 1×1 → hi=1, lo=0.
- **Hazard stall:** MULTU 2×3, then MFLO at T0+1 → `stall` high for 33 cycles; MFLO reads 6. An independent ALU op at T0+1 is not stalled.
- **Abort paths:** `kill` at T0+10 → busy=0 at T0+11, HI/LO unchanged, no `done`. `reset_n` low at T0+5 → hi=lo=0, busy=0 immediately.
